// File: rtl/apb4_pkg.sv
// Shared APB4 completer types: FSM states, PPROT bit positions, strobe width.
package apb4_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        DONE
    } apb_state_e;

    localparam int PROT_PRIV  = 0;
    localparam int PROT_NSEC  = 1;
    localparam int PROT_INSTR = 2;

    localparam int STRB_W = 4;

endpackage

// File: rtl/apb4_strb_merge.sv
// Byte-lane merge of an old memory word with write data under PSTRB.
module apb4_strb_merge
    import apb4_pkg::*;
(
    input  logic [STRB_W*8-1:0] i_old,
    input  logic [STRB_W*8-1:0] i_wdata,
    input  logic [STRB_W-1:0]   i_strb,
    output logic [STRB_W*8-1:0] o_word
);

    always_comb begin
        o_word = i_old;
        for (int i = 0; i < STRB_W; i++) begin
            if (i_strb[i]) begin
                o_word[8*i +: 8] = i_wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/apb4_completer_mem.sv
// APB4 completer backed by a word memory with wait states and PSLVERR.
// Optional: define APB_SECURE_CHECK_EN to reject non-secure upper-half access.
module apb4_completer_mem
    import apb4_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic                    PCLK,
    input  logic                    PRESETn,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [ADDR_WIDTH-1:0]   PADDR,
    input  logic [DATA_WIDTH-1:0]   PWDATA,
    input  logic [DATA_WIDTH/8-1:0] PSTRB,
    input  logic [2:0]              PPROT,
    output logic                    PREADY,
    output logic [DATA_WIDTH-1:0]   PRDATA,
    output logic                    PSLVERR
);

    localparam int IDX_W = $clog2(MEM_DEPTH);

    apb_state_e r_state;
    logic [3:0] r_cnt;
    logic       r_pready;
    logic       r_slverr;
    logic [DATA_WIDTH-1:0] r_prdata;

    logic [ADDR_WIDTH-1:0]   r_addr;
    logic                    r_write;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [DATA_WIDTH/8-1:0] r_strb;
    logic [2:0]              r_prot;

    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

    apb_state_e w_phase;
    apb_state_e w_next;
    logic [3:0] w_cnt_next;
    logic       w_complete;
    logic       w_setup;

    logic [ADDR_WIDTH-1:0]   w_addr;
    logic                    w_write;
    logic [DATA_WIDTH-1:0]   w_wdata;
    logic [DATA_WIDTH/8-1:0] w_strb;
    logic [2:0]              w_prot;
    logic [IDX_W-1:0]        w_idx;
    logic                    w_oor;
    logic                    w_sec_err;
    logic                    w_err;
    logic [DATA_WIDTH-1:0]   w_old;
    logic [DATA_WIDTH-1:0]   w_merged;
    logic                    w_unused;

    // SETUP is the bus setup phase sampled from IDLE/DONE at the edge.
    always_comb begin
        w_phase = r_state;
        if ((r_state == IDLE || r_state == DONE) && PSEL && !PENABLE) begin
            w_phase = SETUP;
        end
    end

    assign w_setup = (w_phase == SETUP);

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        w_complete = 1'b0;
        unique case (w_phase)
            IDLE: begin
                w_next = IDLE;
            end
            SETUP: begin
                w_next     = ACCESS;
                w_cnt_next = 4'(WAIT_STATES);
                if (WAIT_STATES == 0) begin
                    w_complete = 1'b1;
                end
            end
            ACCESS: begin
                if (r_pready) begin
                    w_next     = DONE;
                    w_cnt_next = 4'd0;
                end else if (!PSEL) begin
                    w_next     = IDLE;
                    w_cnt_next = 4'd0;
                end else if (r_cnt <= 4'd1) begin
                    w_cnt_next = 4'd0;
                    w_complete = 1'b1;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            DONE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Zero-wait transfers complete on the setup edge, so use the live bus.
    assign w_addr  = w_setup ? PADDR  : r_addr;
    assign w_write = w_setup ? PWRITE : r_write;
    assign w_wdata = w_setup ? PWDATA : r_wdata;
    assign w_strb  = w_setup ? PSTRB  : r_strb;
    assign w_prot  = w_setup ? PPROT  : r_prot;

    assign w_idx = w_addr[IDX_W+1:2];
    assign w_oor = |w_addr[ADDR_WIDTH-1:IDX_W+2];

`ifdef APB_SECURE_CHECK_EN
    assign w_sec_err = w_prot[PROT_NSEC] & w_idx[IDX_W-1];
`else
    assign w_sec_err = 1'b0;
`endif

    assign w_err = w_oor | (!w_write && (|w_strb)) | w_sec_err;

    assign w_old = r_mem[w_idx];

    apb4_strb_merge u_merge (
        .i_old   (w_old),
        .i_wdata (w_wdata),
        .i_strb  (w_strb),
        .o_word  (w_merged)
    );

    assign w_unused = ^{w_addr[1:0], w_prot};

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            r_state  <= IDLE;
            r_cnt    <= 4'd0;
            r_pready <= 1'b0;
            r_slverr <= 1'b0;
            r_prdata <= '0;
            r_addr   <= '0;
            r_write  <= 1'b0;
            r_wdata  <= '0;
            r_strb   <= '0;
            r_prot   <= '0;
        end else begin
            r_state  <= w_next;
            r_cnt    <= w_cnt_next;
            r_pready <= w_complete;
            r_slverr <= w_complete & w_err;
            if (w_setup) begin
                r_addr  <= PADDR;
                r_write <= PWRITE;
                r_wdata <= PWDATA;
                r_strb  <= PSTRB;
                r_prot  <= PPROT;
            end
            if (w_complete && !w_write) begin
                r_prdata <= w_err ? '0 : w_old;
            end
        end
    end

    // Memory has no reset; contents survive PRESETn.
    always_ff @(posedge PCLK) begin
        if (PRESETn && w_complete && w_write && !w_err) begin
            r_mem[w_idx] <= w_merged;
        end
    end

    assign PREADY  = r_pready;
    assign PRDATA  = r_prdata;
    assign PSLVERR = r_slverr;

endmodule
